memory_control: RTL and testbench
=================================

Name: memory_control

Overview:
- Responder end of the caches_if protocol. Serves icache fetch requests (iREN/iaddr) and dcache requests (dREN/dWEN/daddr/dstore).
- Arbitrates both onto the single RAM port and returns iwait/iload and dwait/dload.
- Sits between the cache pair and the RAM model. A registered grant FSM owns the RAM for one access at a time.

Parameters:
- TIMEOUT, 1023: wait cycles allowed in one service before the sticky error flag sets.
- CNT_W, 10: width of the wait-cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  system clock; one clock domain, all state on rising edge.
- nRST  in  1  synchronous active-low reset, sampled on CLK rising edge.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  0 = iload valid this cycle.
- iload  out  32  instruction word.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  0 = dcache access completes this cycle.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- merr  out  1  sticky timeout or RAM-error flag.

Behaviour:
- Reset (nRST low at an edge): state IDLE, last_grant = I, counter 0, merr 0.
- Reset output values: iwait = dwait = 1; iload = dload = 0; ramREN = ramWEN = 0; ramaddr = ramstore = 0.
- Reset mid-access abandons the access; no wait is dropped in that cycle or the one after.
- FSM states: IDLE, SERVE_I, SERVE_D. All outputs are combinational from the registered state plus the inputs.
- IDLE:
  - No RAM enables asserted; both waits held at 1.
  - dreq = dREN|dWEN.
  - dreq only -> SERVE_D. iREN only -> SERVE_I.
  - Both pending -> serve the port not equal to last_grant (round robin); when last_grant = I, the D port wins.
  - Arbitration latency is one cycle. A request first seen in cycle N drives the RAM from cycle N+1.
- SERVE_D:
  - ramaddr = daddr.
  - dWEN = 1: ramWEN = 1, ramstore = dstore.
  - Otherwise ramREN = 1.
  - dREN and dWEN both high is treated as a write.
- SERVE_I: ramREN = 1, ramaddr = iaddr.
- Completion:
  - While granted and ramstate != ACCESS: granted wait = 1, counter increments.
  - On ramstate == ACCESS: granted wait = 0 for exactly that cycle.
  - Granted load = ramload (reads only; dload = 0 on writes).
  - Same cycle: last_grant <= granted port, counter cleared.
  - Next state is the other port if its request is pending, else IDLE. Back-to-back service is permitted, with no IDLE bubble.
- Ungranted port: wait = 1, load = 0.
- Requester withdraws (granted REN/WEN drops before ACCESS): RAM enables drop the same cycle, FSM -> IDLE, counter cleared, no wait deasserted.
- Request changes mid-service:
  - Address and data are not latched; the RAM sees the live inputs.
  - Requesters hold them stable while wait = 1 (protocol rule, not checked).
- ramstate == ERROR while granted: treated as BUSY, merr <= 1.
- Counter reaching TIMEOUT: merr <= 1; the counter saturates and the service continues.
- merr clears only on reset.
- Counter uses unsigned CNT_W arithmetic; it never wraps.

Decomposition:
- cpu_types_pkg supplies word_t and ramstate_t (FREE/BUSY/ACCESS/ERROR).
- Add to cpu_types_pkg: mc_state_t (IDLE, SERVE_I, SERVE_D) and grant_t (GRANT_I, GRANT_D).
- Connect through caches_if.cc (cache side) and the cpu_ram_if ram modport.
- One natural sub-module: mc_arbiter. It is the combinational round-robin pick from dreq, iREN and last_grant, plus the last_grant register. The FSM and RAM muxing stay in the top.

Test Plan:
- Reset: hold nRST low 2 cycles with iREN = 1 -> iwait = 1, dwait = 1, ramREN = 0, ramWEN = 0, merr = 0. Release -> SERVE_I next cycle.
- I fetch: iREN = 1, iaddr = 0x40, RAM gives BUSY ×2 then ACCESS with ramload = 0x8C220004 -> ramaddr = 0x40, iwait low exactly on the ACCESS cycle, iload = 0x8C220004, next state IDLE.
- D write: dWEN = 1, daddr = 0x100, dstore = 0xDEADBEEF -> ramWEN = 1, ramstore = 0xDEADBEEF, ramREN = 0. dwait low on ACCESS, dload = 0.
- Contention: iREN and dREN raised together from reset (last_grant = I) -> D served first. I served back-to-back next cycle with no IDLE. With last_grant = D and both pending again, I wins.
- Withdraw: iREN drops after 1 BUSY cycle -> ramREN = 0 the same cycle, FSM back to IDLE, iwait never 0.
- Error: TIMEOUT = 4, ramstate stuck at BUSY for 6 cycles -> merr = 1 from cycle 5 and stays 1 after a later ACCESS. An ERROR ramstate also sets merr.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: data word, RAM handshake state and
// the memory controller's FSM and grant encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } mc_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mc_arbiter.sv
// Round-robin pick between the icache and dcache ports,
// plus the register remembering which port was served last.
module mc_arbiter
    import cpu_types_pkg::*;
(
    input  logic CLK,
    input  logic nRST,
    input  logic i_dreq,
    input  logic i_ireq,
    input  logic i_upd,
    input  logic i_upd_d,
    output logic o_pick_d
);

    grant_t r_last;
    logic   w_pick_d;

    // Favour the port that was not served last when both request
    always_comb begin
        w_pick_d = 1'b0;
        if (i_dreq && i_ireq) begin
            w_pick_d = (r_last == GRANT_I);
        end else begin
            w_pick_d = i_dreq;
        end
    end

    // Record the port whose access just completed
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_last <= GRANT_I;
        end else if (i_upd) begin
            r_last <= i_upd_d ? GRANT_D : GRANT_I;
        end
    end

    assign o_pick_d = w_pick_d;

endmodule

// File: rtl/memory_control.sv
// Memory controller: arbitrates icache and dcache requests onto
// the single RAM port and returns wait/load to each cache.
module memory_control
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        merr
);

    localparam logic [CNT_W-1:0] LP_TMO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_TMO_M1 = CNT_W'(TIMEOUT - 1);

    mc_state_t        r_state;
    mc_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_merr;
    logic             w_dreq;
    logic             w_acc;
    logic             w_rerr;
    logic             w_pick_d;
    logic             w_done;
    logic             w_done_d;
    logic             w_clr;
    logic             w_inc;
    logic             w_err;

    assign w_dreq   = dREN | dWEN;
    assign w_acc    = (ramstate_t'(ramstate) == ACCESS);
    assign w_rerr   = (ramstate_t'(ramstate) == ERROR);
    assign w_done_d = (r_state == SERVE_D);
    assign merr     = r_merr;

    mc_arbiter u_arb (
        .CLK      (CLK),
        .nRST     (nRST),
        .i_dreq   (w_dreq),
        .i_ireq   (iREN),
        .i_upd    (w_done),
        .i_upd_d  (w_done_d),
        .o_pick_d (w_pick_d)
    );

    // Next state, RAM muxing and cache responses; all quiet during reset
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        w_next   = r_state;
        w_done   = 1'b0;
        w_clr    = 1'b0;
        w_inc    = 1'b0;
        w_err    = 1'b0;
        if (nRST) begin
            case (r_state)
                IDLE: begin
                    if (w_dreq || iREN) begin
                        w_next = w_pick_d ? SERVE_D : SERVE_I;
                    end
                end
                SERVE_I: begin
                    if (!iREN) begin
                        w_next = IDLE;
                        w_clr  = 1'b1;
                    end else begin
                        ramREN  = 1'b1;
                        ramaddr = iaddr;
                        if (w_acc) begin
                            iwait  = 1'b0;
                            iload  = ramload;
                            w_done = 1'b1;
                            w_clr  = 1'b1;
                            w_next = w_dreq ? SERVE_D : IDLE;
                        end else begin
                            w_inc = 1'b1;
                            w_err = w_rerr;
                        end
                    end
                end
                SERVE_D: begin
                    if (!w_dreq) begin
                        w_next = IDLE;
                        w_clr  = 1'b1;
                    end else begin
                        ramaddr = daddr;
                        if (dWEN) begin
                            ramWEN   = 1'b1;
                            ramstore = dstore;
                        end else begin
                            ramREN = 1'b1;
                        end
                        if (w_acc) begin
                            dwait  = 1'b0;
                            dload  = dWEN ? '0 : ramload;
                            w_done = 1'b1;
                            w_clr  = 1'b1;
                            w_next = iREN ? SERVE_I : IDLE;
                        end else begin
                            w_inc = 1'b1;
                            w_err = w_rerr;
                        end
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Grant FSM state register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Wait-cycle counter, saturating at the timeout value
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (w_clr) begin
            r_cnt <= '0;
        end else if (w_inc && (r_cnt != LP_TMO)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Sticky error: RAM error while granted, or the wait hits the timeout
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_merr <= 1'b0;
        end else if (w_err || (w_inc && (r_cnt >= LP_TMO_M1))) begin
            r_merr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_control.sv
// Scoreboard bench for memory_control: directed protocol cases
// followed by random traffic against a RAM model.
module tb_memory_control;
    import cpu_types_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] store;
        logic [31:0] load;
    } exp_t;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        merr;

    logic        auto_ram = 1'b0;
    logic [1:0]  m_state = FREE;
    logic [31:0] m_load = '0;
    logic [1:0]  a_state = FREE;
    logic [31:0] a_load = '0;
    int          lat = 0;

    int total = 0;
    int bad = 0;

    exp_t iq[$];
    exp_t dq[$];
    exp_t mi;
    exp_t md;

    logic [31:0] ram_mem[logic [31:0]];
    logic [31:0] dmodel[logic [31:0]];

    assign ramstate = auto_ram ? a_state : m_state;
    assign ramload  = auto_ram ? a_load : m_load;

    memory_control #(
        .TIMEOUT (4),
        .CNT_W   (10)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .merr     (merr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%b exp=%b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    // Instruction region content (never written)
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        if (a < 32'h1000) return rom(a);
        return ~a;
    endfunction

    // Monitor: pop one expectation per completed access
    always @(negedge CLK) begin
        if (iwait === 1'b0) begin
            if (iq.size() == 0) begin
                chk1("i_unexpected_done", iwait, 1'b1);
            end else begin
                mi = iq.pop_front();
                chk("iload", iload, mi.load);
                chk("i_ramaddr", ramaddr, mi.addr);
                chk1("i_ramREN", ramREN, 1'b1);
            end
        end
        if (dwait === 1'b0) begin
            if (dq.size() == 0) begin
                chk1("d_unexpected_done", dwait, 1'b1);
            end else begin
                md = dq.pop_front();
                chk("dload", dload, md.load);
                chk("d_ramaddr", ramaddr, md.addr);
                chk1("d_ramWEN", ramWEN, md.wr);
                chk1("d_ramREN", ramREN, !md.wr);
                if (md.wr) chk("d_ramstore", ramstore, md.store);
            end
        end
    end

    // RAM model: random latency, answers from its own array
    always @(posedge CLK) begin
        #2;
        if (auto_ram && (ramREN || ramWEN)) begin
            if (lat == 0) begin
                a_state = ACCESS;
                a_load  = rd(ramaddr);
                lat     = $urandom_range(0, 2);
            end else begin
                a_state = BUSY;
                a_load  = $urandom;
                lat     = lat - 1;
            end
        end else begin
            a_state = FREE;
        end
    end

    always @(negedge CLK) begin
        if (auto_ram && ramstate == ACCESS && ramWEN) begin
            ram_mem[ramaddr] = ramstore;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 0; iREN = 1; iaddr = 32'h40;
        dREN = 0; dWEN = 0; daddr = 0; dstore = 0;

        // reset held two cycles with a fetch pending
        repeat (2) begin
            step();
            smp();
            chk1("rst_iwait", iwait, 1'b1);
            chk1("rst_dwait", dwait, 1'b1);
            chk1("rst_ramREN", ramREN, 1'b0);
            chk1("rst_ramWEN", ramWEN, 1'b0);
            chk1("rst_merr", merr, 1'b0);
        end
        step(); nRST = 1;
        smp(); chk1("idle_ramREN", ramREN, 1'b0);

        // I fetch: BUSY x2 then ACCESS
        step(); m_state = BUSY;
        smp();
        chk1("serve_i_ramREN", ramREN, 1'b1);
        chk("serve_i_ramaddr", ramaddr, 32'h40);
        chk1("busy_iwait", iwait, 1'b1);
        step();
        smp(); chk1("busy2_iwait", iwait, 1'b1);
        step(); m_state = ACCESS; m_load = 32'h8C220004;
        iq.push_back('{32'h40, 1'b0, 32'h0, 32'h8C220004});
        smp();
        step(); iREN = 0; m_state = FREE;
        smp(); chk1("ifetch_idle", ramREN, 1'b0);

        // D write
        step(); dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        smp(); chk1("dw_idle_ramWEN", ramWEN, 1'b0);
        step(); m_state = BUSY;
        smp();
        chk1("dw_ramWEN", ramWEN, 1'b1);
        chk1("dw_ramREN", ramREN, 1'b0);
        chk("dw_ramstore", ramstore, 32'hDEADBEEF);
        chk("dw_ramaddr", ramaddr, 32'h100);
        chk1("dw_dwait", dwait, 1'b1);
        step(); m_state = ACCESS; m_load = 32'h55555555;
        dq.push_back('{32'h100, 1'b1, 32'hDEADBEEF, 32'h0});
        smp();
        step(); dWEN = 0; m_state = FREE;

        // contention from reset: D first, then I back-to-back
        nRST = 0;
        step(); nRST = 1; iREN = 1; dREN = 1;
        iaddr = 32'h80; daddr = 32'h200;
        smp(); chk1("ct_idle", ramREN, 1'b0);
        step(); m_state = ACCESS; m_load = 32'hA0A0A0A0;
        dq.push_back('{32'h200, 1'b0, 32'h0, 32'hA0A0A0A0});
        smp(); chk1("ct_iwait_hold", iwait, 1'b1);
        step(); dREN = 0; m_state = BUSY;
        smp();
        chk1("b2b_ramREN", ramREN, 1'b1);
        chk("b2b_ramaddr", ramaddr, 32'h80);
        step(); m_state = ACCESS; m_load = 32'hB0B0B0B0;
        iq.push_back('{32'h80, 1'b0, 32'h0, 32'hB0B0B0B0});
        smp();
        step(); iREN = 0; dREN = 1; daddr = 32'h204; m_load = 32'hC0C0C0C0;
        smp(); chk1("ct_d_idle", dwait, 1'b1);
        step();
        dq.push_back('{32'h204, 1'b0, 32'h0, 32'hC0C0C0C0});
        smp();
        step(); daddr = 32'h208; iREN = 1; iaddr = 32'h84; m_state = BUSY;
        smp(); chk1("rr_idle", ramREN, 1'b0);
        step();
        smp();
        chk("rr_i_wins", ramaddr, 32'h84);
        chk1("rr_ramREN", ramREN, 1'b1);
        step(); m_state = ACCESS; m_load = 32'hD0D0D0D0;
        iq.push_back('{32'h84, 1'b0, 32'h0, 32'hD0D0D0D0});
        smp();
        step(); iREN = 0; m_load = 32'hE0E0E0E0;
        dq.push_back('{32'h208, 1'b0, 32'h0, 32'hE0E0E0E0});
        smp();
        step(); dREN = 0; m_state = FREE;

        // withdraw after one BUSY cycle
        step(); iREN = 1; iaddr = 32'h44;
        smp();
        step(); m_state = BUSY;
        smp(); chk1("wd_pre_ramREN", ramREN, 1'b1);
        step(); iREN = 0;
        smp();
        chk1("wd_ramREN", ramREN, 1'b0);
        chk1("wd_iwait", iwait, 1'b1);
        step(); iREN = 1; m_state = ACCESS; m_load = 32'hF00DF00D;
        smp(); chk1("wd_back_idle", ramREN, 1'b0);
        step();
        iq.push_back('{32'h44, 1'b0, 32'h0, 32'hF00DF00D});
        smp();
        step(); iREN = 0; m_state = FREE;

        // timeout: TIMEOUT=4, BUSY for 6 cycles
        smp(); chk1("tmo_merr0", merr, 1'b0);
        step(); iREN = 1; iaddr = 32'h48; m_state = BUSY;
        smp();
        for (int k = 1; k <= 6; k++) begin
            step();
            smp();
            chk1($sformatf("tmo_merr_c%0d", k), merr, k >= 5);
        end
        step(); m_state = ACCESS; m_load = 32'h12345678;
        iq.push_back('{32'h48, 1'b0, 32'h0, 32'h12345678});
        smp();
        step(); iREN = 0; m_state = FREE;
        smp(); chk1("tmo_sticky", merr, 1'b1);

        // RAM ERROR sets merr; reset mid-access drops no wait
        step(); nRST = 0;
        step(); nRST = 1; dREN = 1; daddr = 32'h300;
        smp(); chk1("err_merr0", merr, 1'b0);
        step(); m_state = ERROR;
        smp();
        chk1("err_dwait", dwait, 1'b1);
        chk1("err_merr_pre", merr, 1'b0);
        step(); m_state = BUSY;
        smp(); chk1("err_merr", merr, 1'b1);
        step(); nRST = 0; m_state = ACCESS; m_load = 32'h77777777;
        smp();
        chk1("rst_mid_dwait", dwait, 1'b1);
        chk1("rst_mid_ramREN", ramREN, 1'b0);
        step(); nRST = 1;
        smp(); chk1("rst_after_dwait", dwait, 1'b1);
        step();
        dq.push_back('{32'h300, 1'b0, 32'h0, 32'h77777777});
        smp();
        step(); dREN = 0; m_state = FREE;

        // random traffic against the RAM model
        step(); nRST = 0;
        step(); nRST = 1; auto_ram = 1;
        fork
            begin
                int  igap;
                bit  igot;
                logic [31:0] ia;
                for (int n = 0; n < 60; n++) begin
                    step();
                    igap = $urandom_range(0, 2);
                    if (igap != 0) begin
                        iREN = 0;
                        repeat (igap) step();
                    end
                    ia = 32'($urandom_range(0, 255)) << 2;
                    iaddr = ia;
                    iREN = 1;
                    iq.push_back('{ia, 1'b0, 32'h0, rom(ia)});
                    igot = 0;
                    for (int c = 0; c < 60 && !igot; c++) begin
                        smp();
                        if (iwait === 1'b0) igot = 1;
                    end
                    if (!igot) begin
                        total++; bad++;
                        $display("FAIL i_timeout act=no_done exp=done");
                    end
                end
                step(); iREN = 0;
            end
            begin
                int  dgap;
                bit  dgot;
                logic        w;
                logic [31:0] da;
                logic [31:0] ds;
                logic [31:0] dl;
                for (int n = 0; n < 60; n++) begin
                    step();
                    dgap = $urandom_range(0, 2);
                    if (dgap != 0) begin
                        dREN = 0; dWEN = 0;
                        repeat (dgap) step();
                    end
                    w  = 1'($urandom_range(0, 1));
                    da = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
                    ds = $urandom;
                    dl = dmodel.exists(da) ? dmodel[da] : ~da;
                    if (w) begin
                        dl = 32'h0;
                        dmodel[da] = ds;
                    end
                    daddr = da; dstore = ds;
                    dWEN = w;
                    dREN = w ? 1'($urandom_range(0, 1)) : 1'b1;
                    dq.push_back('{da, w, ds, dl});
                    dgot = 0;
                    for (int c = 0; c < 60 && !dgot; c++) begin
                        smp();
                        if (dwait === 1'b0) dgot = 1;
                    end
                    if (!dgot) begin
                        total++; bad++;
                        $display("FAIL d_timeout act=no_done exp=done");
                    end
                end
                step(); dREN = 0; dWEN = 0;
            end
        join
        repeat (3) step();
        chk("iq_drained", iq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        chk1("rand_merr", merr, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
